// File: rtl/spmv_row_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : spmv_row_dispatch_if
// Brief    : AXI-Stream bundle for the SpMV row dispatcher: PTR/VAL/XV in, TIMES/A/B out.
// Revision : 1.0
// ============================================================================
interface spmv_row_dispatch_if #(
    parameter int PTR_W  = 32,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
);
    logic [PTR_W-1:0]  S_AXIS_PTR_tdata;
    logic              S_AXIS_PTR_tvalid;
    logic              S_AXIS_PTR_tready;
    logic [DATA_W-1:0] S_AXIS_VAL_tdata;
    logic              S_AXIS_VAL_tvalid;
    logic              S_AXIS_VAL_tready;
    logic [DATA_W-1:0] S_AXIS_XV_tdata;
    logic              S_AXIS_XV_tvalid;
    logic              S_AXIS_XV_tready;
    logic [CNT_W-1:0]  M_AXIS_TIMES_tdata;
    logic              M_AXIS_TIMES_tvalid;
    logic              M_AXIS_TIMES_tready;
    logic [DATA_W-1:0] M_AXIS_A_tdata;
    logic              M_AXIS_A_tvalid;
    logic              M_AXIS_A_tready;
    logic [DATA_W-1:0] M_AXIS_B_tdata;
    logic              M_AXIS_B_tvalid;
    logic              M_AXIS_B_tready;

    // slave: the dispatcher's view; master: the surrounding DMA / kernel view
    modport slave (
        input  S_AXIS_PTR_tdata, S_AXIS_PTR_tvalid, output S_AXIS_PTR_tready,
        input  S_AXIS_VAL_tdata, S_AXIS_VAL_tvalid, output S_AXIS_VAL_tready,
        input  S_AXIS_XV_tdata,  S_AXIS_XV_tvalid,  output S_AXIS_XV_tready,
        output M_AXIS_TIMES_tdata, M_AXIS_TIMES_tvalid, input M_AXIS_TIMES_tready,
        output M_AXIS_A_tdata,     M_AXIS_A_tvalid,     input M_AXIS_A_tready,
        output M_AXIS_B_tdata,     M_AXIS_B_tvalid,     input M_AXIS_B_tready
    );

    modport master (
        output S_AXIS_PTR_tdata, S_AXIS_PTR_tvalid, input S_AXIS_PTR_tready,
        output S_AXIS_VAL_tdata, S_AXIS_VAL_tvalid, input S_AXIS_VAL_tready,
        output S_AXIS_XV_tdata,  S_AXIS_XV_tvalid,  input S_AXIS_XV_tready,
        input  M_AXIS_TIMES_tdata, M_AXIS_TIMES_tvalid, output M_AXIS_TIMES_tready,
        input  M_AXIS_A_tdata,     M_AXIS_A_tvalid,     output M_AXIS_A_tready,
        input  M_AXIS_B_tdata,     M_AXIS_B_tvalid,     output M_AXIS_B_tready
    );
endinterface
`default_nettype wire

// File: rtl/spmv_row_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : spmv_row_dispatch
// Brief    : Turns CSR row pointers into per-row nnz counts and forwards that many VAL/XV beats.
// Revision : 1.0
// ============================================================================
module spmv_row_dispatch #(
    parameter int PTR_W  = 32,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start_i,
    input  wire logic [CNT_W-1:0] num_rows_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_ptr_o,
    spmv_row_dispatch_if.slave    axis
);
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_BASE  = 3'd1,
        S_LOAD_NEXT  = 3'd2,
        S_EMIT_TIMES = 3'd3,
        S_STREAM     = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] C_ROW_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rows_left_q, rows_left_d;
    logic [PTR_W-1:0]  prev_q, prev_d;
    logic [PTR_W-1:0]  cur_q, cur_d;
    logic [PTR_W-1:0]  nnz_q, nnz_d;
    logic [PTR_W-1:0]  a_rem_q, a_rem_d;
    logic [PTR_W-1:0]  b_rem_q, b_rem_d;
    logic              err_q, err_d;

    logic              w_ptr_tready, w_val_tready, w_xv_tready;
    logic              w_times_tvalid, w_a_tvalid, w_b_tvalid;
    logic [DATA_W-1:0] w_a_data, w_b_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rows_left_q <= '0;
            prev_q      <= '0;
            cur_q       <= '0;
            nnz_q       <= '0;
            a_rem_q     <= '0;
            b_rem_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_left_q <= rows_left_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            nnz_q       <= nnz_d;
            a_rem_q     <= a_rem_d;
            b_rem_q     <= b_rem_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rows_left_d    = rows_left_q;
        prev_d         = prev_q;
        cur_d          = cur_q;
        nnz_d          = nnz_q;
        a_rem_d        = a_rem_q;
        b_rem_d        = b_rem_q;
        err_d          = err_q;
        w_ptr_tready   = 1'b0;
        w_val_tready   = 1'b0;
        w_xv_tready    = 1'b0;
        w_times_tvalid = 1'b0;
        w_a_tvalid     = 1'b0;
        w_b_tvalid     = 1'b0;
        done_o         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rows_left_d = num_rows_i;
                    err_d       = 1'b0;
                    state_d     = (num_rows_i == '0) ? S_DONE : S_LOAD_BASE;
                end
            end
            S_LOAD_BASE: begin
                w_ptr_tready = 1'b1;
                if (axis.S_AXIS_PTR_tvalid) begin
                    prev_d  = axis.S_AXIS_PTR_tdata;
                    state_d = S_LOAD_NEXT;
                end
            end
            S_LOAD_NEXT: begin
                w_ptr_tready = 1'b1;
                if (axis.S_AXIS_PTR_tvalid) begin
                    cur_d = axis.S_AXIS_PTR_tdata;
                    // A decreasing pointer is flagged and treated as an empty row
                    if (axis.S_AXIS_PTR_tdata < prev_q) begin
                        nnz_d = '0;
                        err_d = 1'b1;
                    end else begin
                        nnz_d = axis.S_AXIS_PTR_tdata - prev_q;
                    end
                    rows_left_d = rows_left_q - C_ROW_ONE;
                    state_d     = S_EMIT_TIMES;
                end
            end
            S_EMIT_TIMES: begin
                w_times_tvalid = 1'b1;
                if (axis.M_AXIS_TIMES_tready) begin
                    a_rem_d = nnz_q;
                    b_rem_d = nnz_q;
                    prev_d  = cur_q;
                    if (nnz_q != '0) begin
                        state_d = S_STREAM;
                    end else begin
                        state_d = (rows_left_q != '0) ? S_LOAD_NEXT : S_DONE;
                    end
                end
            end
            S_STREAM: begin
                w_a_tvalid   = axis.S_AXIS_VAL_tvalid & (a_rem_q != '0);
                w_val_tready = axis.M_AXIS_A_tready   & (a_rem_q != '0);
                w_b_tvalid   = axis.S_AXIS_XV_tvalid  & (b_rem_q != '0);
                w_xv_tready  = axis.M_AXIS_B_tready   & (b_rem_q != '0);
                if (w_a_tvalid && axis.M_AXIS_A_tready) begin
                    a_rem_d = a_rem_q - C_PTR_ONE;
                end
                if (w_b_tvalid && axis.M_AXIS_B_tready) begin
                    b_rem_d = b_rem_q - C_PTR_ONE;
                end
                // Leave on the final handshake so the row costs no extra idle cycle
                if ((a_rem_d == '0) && (b_rem_d == '0)) begin
                    state_d = (rows_left_q != '0) ? S_LOAD_NEXT : S_DONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign err_ptr_o = err_q;

    assign w_a_data = axis.S_AXIS_VAL_tdata;
    assign w_b_data = axis.S_AXIS_XV_tdata;

    assign axis.S_AXIS_PTR_tready   = w_ptr_tready;
    assign axis.S_AXIS_VAL_tready   = w_val_tready;
    assign axis.S_AXIS_XV_tready    = w_xv_tready;
    assign axis.M_AXIS_TIMES_tvalid = w_times_tvalid;
    assign axis.M_AXIS_TIMES_tdata  = CNT_W'(nnz_q);
    assign axis.M_AXIS_A_tvalid     = w_a_tvalid;
    assign axis.M_AXIS_A_tdata      = w_a_data;
    assign axis.M_AXIS_B_tvalid     = w_b_tvalid;
    assign axis.M_AXIS_B_tdata      = w_b_data;
endmodule
`default_nettype wire

// File: tb/tb_spmv_row_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_spmv_row_dispatch
// Brief    : Self-checking bench: constant vector table, corner sequences, random matrices vs a CSR model.
// Revision : 1.0
// ============================================================================
module tb_spmv_row_dispatch;
    localparam int PTR_W  = 32;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_rows = '0;
    logic             busy, done, err_ptr;

    spmv_row_dispatch_if #(.PTR_W(PTR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    spmv_row_dispatch #(.PTR_W(PTR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .num_rows_i (num_rows),
        .busy_o     (busy),
        .done_o     (done),
        .err_ptr_o  (err_ptr),
        .axis       (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [PTR_W-1:0]  ptr_src[$];
    logic [DATA_W-1:0] val_src[$], xv_src[$];
    logic [CNT_W-1:0]  times_obs[$];
    logic [DATA_W-1:0] a_obs[$], b_obs[$];
    int times_cyc[$], a_cyc[$], b_cyc[$];
    int cyc = 0;
    int done_cnt, done_cyc, busy_at_done, ptr_taken, val_taken, xv_taken, ptr_rdy_cnt;
    int vld_pct = 100, rdy_pct = 100, b_block = 0;

    // Reference model inputs/outputs
    int unsigned exp_ptr[$];
    int unsigned exp_times[$];
    bit          exp_err;
    int          exp_total;

    typedef struct {
        int          nrows;
        int unsigned ptr[8];
        int unsigned times[7];
        bit          err;
        int          lat;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : drv_ptr
        bit acc;
        bus.S_AXIS_PTR_tvalid = 1'b0;
        bus.S_AXIS_PTR_tdata  = '0;
        forever begin
            @(posedge clk);
            acc = bus.S_AXIS_PTR_tvalid && bus.S_AXIS_PTR_tready;
            if (acc && ptr_src.size() > 0) begin void'(ptr_src.pop_front()); ptr_taken++; end
            @(negedge clk);
            if (!bus.S_AXIS_PTR_tvalid || acc) begin
                if (ptr_src.size() > 0 && int'($urandom_range(99)) < vld_pct) begin
                    bus.S_AXIS_PTR_tvalid = 1'b1;
                    bus.S_AXIS_PTR_tdata  = ptr_src[0];
                end else bus.S_AXIS_PTR_tvalid = 1'b0;
            end
        end
    end

    initial begin : drv_val
        bit acc;
        bus.S_AXIS_VAL_tvalid = 1'b0;
        bus.S_AXIS_VAL_tdata  = '0;
        forever begin
            @(posedge clk);
            acc = bus.S_AXIS_VAL_tvalid && bus.S_AXIS_VAL_tready;
            if (acc && val_src.size() > 0) begin void'(val_src.pop_front()); val_taken++; end
            @(negedge clk);
            if (!bus.S_AXIS_VAL_tvalid || acc) begin
                if (val_src.size() > 0 && int'($urandom_range(99)) < vld_pct) begin
                    bus.S_AXIS_VAL_tvalid = 1'b1;
                    bus.S_AXIS_VAL_tdata  = val_src[0];
                end else bus.S_AXIS_VAL_tvalid = 1'b0;
            end
        end
    end

    initial begin : drv_xv
        bit acc;
        bus.S_AXIS_XV_tvalid = 1'b0;
        bus.S_AXIS_XV_tdata  = '0;
        forever begin
            @(posedge clk);
            acc = bus.S_AXIS_XV_tvalid && bus.S_AXIS_XV_tready;
            if (acc && xv_src.size() > 0) begin void'(xv_src.pop_front()); xv_taken++; end
            @(negedge clk);
            if (!bus.S_AXIS_XV_tvalid || acc) begin
                if (xv_src.size() > 0 && int'($urandom_range(99)) < vld_pct) begin
                    bus.S_AXIS_XV_tvalid = 1'b1;
                    bus.S_AXIS_XV_tdata  = xv_src[0];
                end else bus.S_AXIS_XV_tvalid = 1'b0;
            end
        end
    end

    initial begin : sink_times
        bus.M_AXIS_TIMES_tready = 1'b0;
        forever begin
            @(posedge clk);
            if (bus.M_AXIS_TIMES_tvalid && bus.M_AXIS_TIMES_tready) begin
                times_obs.push_back(bus.M_AXIS_TIMES_tdata);
                times_cyc.push_back(cyc);
            end
            @(negedge clk);
            bus.M_AXIS_TIMES_tready = int'($urandom_range(99)) < rdy_pct;
        end
    end

    initial begin : sink_a
        bus.M_AXIS_A_tready = 1'b0;
        forever begin
            @(posedge clk);
            if (bus.M_AXIS_A_tvalid && bus.M_AXIS_A_tready) begin
                a_obs.push_back(bus.M_AXIS_A_tdata);
                a_cyc.push_back(cyc);
            end
            @(negedge clk);
            bus.M_AXIS_A_tready = int'($urandom_range(99)) < rdy_pct;
        end
    end

    initial begin : sink_b
        bus.M_AXIS_B_tready = 1'b0;
        forever begin
            @(posedge clk);
            if (bus.M_AXIS_B_tvalid && bus.M_AXIS_B_tready) begin
                b_obs.push_back(bus.M_AXIS_B_tdata);
                b_cyc.push_back(cyc);
            end
            @(negedge clk);
            if (b_block > 0) begin
                b_block--;
                bus.M_AXIS_B_tready = 1'b0;
            end else bus.M_AXIS_B_tready = int'($urandom_range(99)) < rdy_pct;
        end
    end

    initial begin : mon_ctrl
        forever begin
            @(posedge clk);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy) busy_at_done++;
            end
            if (bus.S_AXIS_PTR_tready) ptr_rdy_cnt++;
        end
    end

    // Called just after a rising edge, when no driver or monitor is active
    task automatic clear_env();
        ptr_src.delete(); val_src.delete(); xv_src.delete();
        times_obs.delete(); a_obs.delete(); b_obs.delete();
        times_cyc.delete(); a_cyc.delete(); b_cyc.delete();
        bus.S_AXIS_PTR_tvalid = 1'b0;
        bus.S_AXIS_VAL_tvalid = 1'b0;
        bus.S_AXIS_XV_tvalid  = 1'b0;
        done_cnt = 0; busy_at_done = 0; ptr_taken = 0; val_taken = 0; xv_taken = 0;
        ptr_rdy_cnt = 0; b_block = 0;
    endtask

    function automatic logic [8:0] out_vec();
        return {bus.S_AXIS_PTR_tready, bus.S_AXIS_VAL_tready, bus.S_AXIS_XV_tready,
                bus.M_AXIS_TIMES_tvalid, bus.M_AXIS_A_tvalid, bus.M_AXIS_B_tvalid,
                busy, done, err_ptr};
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_env();
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", 64'(out_vec()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // CSR rule: nnz of row i is ptr[i+1]-ptr[i], or 0 (with error) if the pointer falls
    task automatic model(input int nrows);
        exp_times.delete();
        exp_err   = 1'b0;
        exp_total = 0;
        for (int i = 0; i < nrows; i++) begin
            if (exp_ptr[i+1] >= exp_ptr[i]) begin
                exp_times.push_back(exp_ptr[i+1] - exp_ptr[i]);
                exp_total += int'(exp_ptr[i+1] - exp_ptr[i]);
            end else begin
                exp_times.push_back(0);
                exp_err = 1'b1;
            end
        end
    endtask

    task automatic run_matrix(input int nrows, input bit do_rst, input bit extra_start,
                              input int b_stall, output int lat);
        logic [DATA_W-1:0] exp_a[$], exp_b[$];
        int start_cyc, t, mism_a, mism_b;
        if (do_rst) do_reset();
        else begin
            @(posedge clk); #1;
            clear_env();
        end
        model(nrows);
        for (int i = 0; i <= nrows; i++) ptr_src.push_back(exp_ptr[i]);
        ptr_src.push_back(32'd12345);
        for (int i = 0; i < exp_total + 2; i++) begin
            val_src.push_back({$urandom, $urandom});
            xv_src.push_back({$urandom, $urandom});
            if (i < exp_total) begin
                exp_a.push_back(val_src[i]);
                exp_b.push_back(xv_src[i]);
            end
        end
        @(negedge clk);
        start = 1'b1; num_rows = CNT_W'(nrows); start_cyc = cyc; b_block = b_stall;
        @(negedge clk);
        start = 1'b0; num_rows = $urandom;
        if (extra_start) begin
            repeat (2) @(negedge clk);
            start = 1'b1; num_rows = 9;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while (done_cnt == 0 && t < 4000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (6) @(posedge clk);
        #1;
        lat = done_cyc - start_cyc;
        chk("done pulses", 64'(done_cnt), 64'd1);
        chk("busy during done", 64'(busy_at_done), 64'd0);
        chk("busy after done", 64'(busy), 64'd0);
        chk("err_ptr", 64'(err_ptr), 64'(exp_err));
        chk("TIMES count", 64'(times_obs.size()), 64'(exp_times.size()));
        for (int i = 0; i < exp_times.size() && i < times_obs.size(); i++)
            chk($sformatf("TIMES[%0d]", i), 64'(times_obs[i]), 64'(exp_times[i]));
        chk("PTR beats consumed", 64'(ptr_taken), 64'((nrows == 0) ? 0 : nrows + 1));
        chk("VAL beats consumed", 64'(val_taken), 64'(exp_total));
        chk("XV beats consumed", 64'(xv_taken), 64'(exp_total));
        chk("A beats", 64'(a_obs.size()), 64'(exp_total));
        chk("B beats", 64'(b_obs.size()), 64'(exp_total));
        mism_a = 0; mism_b = 0;
        for (int i = 0; i < a_obs.size() && i < exp_total; i++) if (a_obs[i] !== exp_a[i]) mism_a++;
        for (int i = 0; i < b_obs.size() && i < exp_total; i++) if (b_obs[i] !== exp_b[i]) mism_b++;
        chk("A data errors", 64'(mism_a), 64'd0);
        chk("B data errors", 64'(mism_b), 64'd0);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat, p, nr, t;

        // Hand-computed vectors; lat = cycles from start sample to done with no stalls
        tbl[0] = '{nrows: 3, ptr: '{0, 2, 2, 5, 0, 0, 0, 0},  times: '{2, 0, 3, 0, 0, 0, 0}, err: 1'b0, lat: 13};
        tbl[1] = '{nrows: 0, ptr: '{0, 0, 0, 0, 0, 0, 0, 0},  times: '{0, 0, 0, 0, 0, 0, 0}, err: 1'b0, lat: 1};
        tbl[2] = '{nrows: 1, ptr: '{10, 7, 0, 0, 0, 0, 0, 0}, times: '{0, 0, 0, 0, 0, 0, 0}, err: 1'b1, lat: 4};
        tbl[3] = '{nrows: 2, ptr: '{4, 4, 4, 0, 0, 0, 0, 0},  times: '{0, 0, 0, 0, 0, 0, 0}, err: 1'b0, lat: 6};
        tbl[4] = '{nrows: 2, ptr: '{5, 3, 6, 0, 0, 0, 0, 0},  times: '{0, 3, 0, 0, 0, 0, 0}, err: 1'b1, lat: 9};
        tbl[5] = '{nrows: 1, ptr: '{0, 4, 0, 0, 0, 0, 0, 0},  times: '{4, 0, 0, 0, 0, 0, 0}, err: 1'b0, lat: 8};

        vld_pct = 100; rdy_pct = 100;
        for (int v = 0; v < 6; v++) begin
            exp_ptr.delete();
            for (int i = 0; i <= tbl[v].nrows; i++) exp_ptr.push_back(tbl[v].ptr[i]);
            run_matrix(tbl[v].nrows, 1'b1, 1'b0, 0, lat);
            chk($sformatf("vec%0d latency", v), 64'(lat), 64'(tbl[v].lat));
            chk($sformatf("vec%0d err_ptr", v), 64'(err_ptr), 64'(tbl[v].err));
            for (int i = 0; i < tbl[v].nrows && i < times_obs.size(); i++)
                chk($sformatf("vec%0d TIMES[%0d]", v, i), 64'(times_obs[i]), 64'(tbl[v].times[i]));
            if (tbl[v].nrows == 0) chk("PTR ready with zero rows", 64'(ptr_rdy_cnt), 64'd0);
        end

        // err_ptr survives idle cycles and is cleared by the next start
        exp_ptr = '{10, 7};
        run_matrix(1, 1'b1, 1'b0, 0, lat);
        repeat (10) @(posedge clk);
        #1;
        chk("err_ptr sticky while idle", 64'(err_ptr), 64'd1);
        exp_ptr = '{0};
        run_matrix(0, 1'b0, 1'b0, 0, lat);

        // B stalled for 20 cycles inside row 0
        exp_ptr = '{0, 2, 2, 5};
        run_matrix(3, 1'b1, 1'b0, 20, lat);
        chk("A row0 done before first B", 64'(a_cyc.size() > 1 && b_cyc.size() > 0 && a_cyc[1] < b_cyc[0]), 64'd1);
        chk("TIMES row1 after B beat 2", 64'(times_cyc.size() > 1 && b_cyc.size() > 1 && times_cyc[1] > b_cyc[1]), 64'd1);

        // Reset in the middle of row 1 of 3
        do_reset();
        exp_ptr = '{0, 2, 4, 6};
        foreach (exp_ptr[i]) ptr_src.push_back(exp_ptr[i]);
        for (int i = 0; i < 6; i++) begin
            val_src.push_back({$urandom, $urandom});
            xv_src.push_back({$urandom, $urandom});
        end
        @(negedge clk);
        start = 1'b1; num_rows = 3;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (a_obs.size() < 3 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk("busy before mid-stream reset", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("outputs after mid-stream reset", 64'(out_vec()), 64'd0);
        clear_env();
        @(negedge clk);
        rst = 1'b0;
        exp_ptr = '{0, 1};
        run_matrix(1, 1'b0, 1'b0, 0, lat);

        // start while busy must be ignored
        vld_pct = 70; rdy_pct = 70;
        exp_ptr = '{0, 2, 2, 5};
        run_matrix(3, 1'b1, 1'b1, 0, lat);

        // Random matrices with random valid/ready gaps
        for (int r = 0; r < 25; r++) begin
            nr = int'($urandom_range(0, 6));
            p  = int'($urandom_range(0, 100));
            exp_ptr.delete();
            exp_ptr.push_back(p);
            for (int i = 0; i < nr; i++) begin
                if ($urandom_range(0, 9) == 0 && p > 3) p = p - int'($urandom_range(1, 3));
                else p = p + int'($urandom_range(0, 4));
                exp_ptr.push_back(p);
            end
            vld_pct = int'($urandom_range(40, 100));
            rdy_pct = int'($urandom_range(40, 100));
            run_matrix(nr, 1'b1, 1'b0, 0, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
